// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared state encoding, Q-format constants and arctangent table for the CORDIC engine
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITERATE,
        CORRECT,
        DONE
    } cordic_state_t;

    // Reference format of the constants below: Q2.30 in 32 bits.
    localparam int Q_TABLE_W    = 32;
    localparam int Q_TABLE_FRAC = 30;

    localparam logic [Q_TABLE_W-1:0] K_Q30    = 32'h26DD3B6A;
    localparam logic [Q_TABLE_W-1:0] PI_2_Q30 = 32'h6487ED51;

    // floor(atan(2^-i) * 2^30)
    function automatic logic [Q_TABLE_W-1:0] atan_q30(input logic [4:0] i);
        case (i)
            5'd0:    return 32'h3243F6A8;
            5'd1:    return 32'h1DAC6705;
            5'd2:    return 32'h0FADBAFC;
            5'd3:    return 32'h07F56EA6;
            5'd4:    return 32'h03FEAB76;
            5'd5:    return 32'h01FFD55B;
            5'd6:    return 32'h00FFFAAA;
            5'd7:    return 32'h007FFF55;
            5'd8:    return 32'h003FFFEA;
            5'd9:    return 32'h001FFFFD;
            5'd10:   return 32'h000FFFFF;
            5'd11:   return 32'h0007FFFF;
            5'd12:   return 32'h0003FFFF;
            5'd13:   return 32'h0001FFFF;
            5'd14:   return 32'h0000FFFF;
            5'd15:   return 32'h00007FFF;
            5'd16:   return 32'h00003FFF;
            5'd17:   return 32'h00001FFF;
            5'd18:   return 32'h00000FFF;
            5'd19:   return 32'h000007FF;
            5'd20:   return 32'h000003FF;
            5'd21:   return 32'h000001FF;
            5'd22:   return 32'h000000FF;
            5'd23:   return 32'h0000007F;
            5'd24:   return 32'h0000003F;
            5'd25:   return 32'h0000001F;
            5'd26:   return 32'h0000000F;
            5'd27:   return 32'h00000007;
            5'd28:   return 32'h00000003;
            5'd29:   return 32'h00000001;
            default: return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/cordic_iter_engine_if.sv
// rtl/cordic_iter_engine_if.sv - start/ack handshake, operands and results of the CORDIC engine
interface cordic_iter_engine_if #(
    parameter int W = 32
);
    logic         beg_fsm_cordic;
    logic         ack_cordic;
    logic         mode;
    logic [1:0]   shift_region_flag;
    logic [W-1:0] data_x;
    logic [W-1:0] data_y;
    logic [W-1:0] data_z;
    logic         ready_cordic;
    logic         busy;
    logic [W-1:0] result_x;
    logic [W-1:0] result_y;
    logic [W-1:0] result_z;
    logic         overflow_flag;
    logic         range_err;

    modport master (
        output beg_fsm_cordic, ack_cordic, mode, shift_region_flag, data_x, data_y, data_z,
        input  ready_cordic, busy, result_x, result_y, result_z, overflow_flag, range_err
    );

    modport slave (
        input  beg_fsm_cordic, ack_cordic, mode, shift_region_flag, data_x, data_y, data_z,
        output ready_cordic, busy, result_x, result_y, result_z, overflow_flag, range_err
    );

endinterface

// File: rtl/cordic_micro_rotation.sv
// rtl/cordic_micro_rotation.sv - one combinational CORDIC shift-add step on guard-extended x/y/z
module cordic_micro_rotation #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic signed [W+1:0] x_in,
    input  logic signed [W+1:0] y_in,
    input  logic signed [W+1:0] z_in,
    input  logic [SHW-1:0]      shift,
    input  logic                dir_neg,
    input  logic signed [W+1:0] atan_val,
    output logic signed [W+1:0] x_out,
    output logic signed [W+1:0] y_out,
    output logic signed [W+1:0] z_out
);
    logic signed [W+1:0] x_sh;
    logic signed [W+1:0] y_sh;

    assign x_sh = x_in >>> shift;
    assign y_sh = y_in >>> shift;

    always_comb begin
        if (dir_neg) begin
            x_out = x_in + y_sh;
            y_out = y_in - x_sh;
            z_out = z_in + atan_val;
        end else begin
            x_out = x_in - y_sh;
            y_out = y_in + x_sh;
            z_out = z_in - atan_val;
        end
    end

endmodule

// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative CORDIC: load, ITER micro-rotations, quadrant fix and saturation, result hold
module cordic_iter_engine #(
    parameter int W    = 32,
    parameter int ITER = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_iter_engine_if.slave  bus
);
    import cordic_pkg::*;

    localparam int SHW   = $clog2(W);
    localparam int SCALE = Q_TABLE_FRAC - (W - 2);
    localparam logic [SHW-1:0] LAST = SHW'(ITER - 1);

    // Rescale a Q2.30 table constant into the W+2 bit datapath (truncating).
    function automatic logic signed [W+1:0] q_to_dp(input logic [Q_TABLE_W-1:0] v);
        logic signed [Q_TABLE_W+1:0] t;
        t = $signed({2'b00, v}) >>> SCALE;
        return t[W+1:0];
    endfunction

    // Returns {saturated, value}.
    function automatic logic [W:0] sat_w(input logic signed [W+1:0] v);
        if (v[W+1:W-1] == {3{v[W-1]}})
            return {1'b0, v[W-1:0]};
        else if (v[W+1])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    localparam logic signed [W+1:0] K_DP    = q_to_dp(K_Q30);
    localparam logic signed [W+1:0] PI_2_DP = q_to_dp(PI_2_Q30);

    cordic_state_t state, state_nxt;

    logic [SHW-1:0]      cnt;
    logic                op_mode;
    logic [1:0]          op_region;
    logic [W-1:0]        op_x, op_y, op_z;
    logic signed [W+1:0] xr, yr, zr;
    logic signed [W+1:0] x_nx, y_nx, z_nx;
    logic signed [W+1:0] atan_dp, cx, cy, z_ext, z_abs;
    logic                dir_neg, range_bad;
    logic [W:0]          sat_x, sat_y, sat_z;
    logic [W-1:0]        res_x, res_y, res_z;
    logic                ovf_r, rerr_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.beg_fsm_cordic) state_nxt = LOAD;
            LOAD:    state_nxt = ITERATE;
            ITERATE: if (cnt == LAST) state_nxt = CORRECT;
            CORRECT: state_nxt = DONE;
            DONE:    if (bus.ack_cordic) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Rotation drives z to zero, vectoring drives y to zero.
    assign dir_neg = op_mode ? ~yr[W+1] : zr[W+1];
    assign atan_dp = q_to_dp(atan_q30(5'(cnt)));

    cordic_micro_rotation #(.W(W), .SHW(SHW)) u_step (
        .x_in     (xr),
        .y_in     (yr),
        .z_in     (zr),
        .shift    (cnt),
        .dir_neg  (dir_neg),
        .atan_val (atan_dp),
        .x_out    (x_nx),
        .y_out    (y_nx),
        .z_out    (z_nx)
    );

    assign z_ext     = {{2{op_z[W-1]}}, op_z};
    assign z_abs     = z_ext[W+1] ? -z_ext : z_ext;
    assign range_bad = op_mode ? op_x[W-1] : (z_abs > PI_2_DP);

    always_comb begin
        cx = xr;
        cy = yr;
        if (!op_mode) begin
            case (op_region)
                2'b01:   begin cx = -yr; cy = xr;  end
                2'b10:   begin cx = yr;  cy = -xr; end
                2'b11:   begin cx = -xr; cy = -yr; end
                default: ;
            endcase
        end
    end

    assign sat_x = sat_w(cx);
    assign sat_y = sat_w(cy);
    assign sat_z = sat_w(zr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_mode   <= 1'b0;
            op_region <= '0;
            op_x      <= '0;
            op_y      <= '0;
            op_z      <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            res_x     <= '0;
            res_y     <= '0;
            res_z     <= '0;
            ovf_r     <= 1'b0;
            rerr_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.beg_fsm_cordic) begin
                    op_mode   <= bus.mode;
                    op_region <= bus.shift_region_flag;
                    op_x      <= bus.data_x;
                    op_y      <= bus.data_y;
                    op_z      <= bus.data_z;
                    ovf_r     <= 1'b0;
                    rerr_r    <= 1'b0;
                end
                LOAD: begin
                    cnt <= '0;
                    if (op_mode) begin
                        xr <= {{2{op_x[W-1]}}, op_x};
                        yr <= {{2{op_y[W-1]}}, op_y};
                        zr <= '0;
                    end else begin
                        xr <= K_DP;
                        yr <= '0;
                        zr <= z_ext;
                    end
                end
                ITERATE: begin
                    xr  <= x_nx;
                    yr  <= y_nx;
                    zr  <= z_nx;
                    cnt <= (cnt == LAST) ? '0 : cnt + SHW'(1);
                end
                CORRECT: begin
                    res_x  <= sat_x[W-1:0];
                    res_y  <= sat_y[W-1:0];
                    res_z  <= sat_z[W-1:0];
                    ovf_r  <= sat_x[W] | sat_y[W] | sat_z[W];
                    rerr_r <= range_bad;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_cordic  = (state == DONE);
    assign bus.busy          = (state != IDLE);
    assign bus.result_x      = res_x;
    assign bus.result_y      = res_y;
    assign bus.result_z      = res_z;
    assign bus.overflow_flag = ovf_r;
    assign bus.range_err     = rerr_r;

endmodule

// File: doc/cordic_iter_engine.md
CORDIC_ITER_ENGINE -- requirements
Module: cordic_iter_engine

Interface
REQ-001 The module SHALL have parameter W, default 32, meaning the data width of all operands and results, signed two's complement Q2.(W-2).
REQ-002 The module SHALL have parameter ITER, default 24, meaning the number of micro-rotations; legal range 8..W-2.
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 The module SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have port beg_fsm_cordic, input, 1 bit, a start request sampled only in IDLE.
REQ-006 The module SHALL have port ack_cordic, input, 1 bit, by which the consumer acknowledges the result.
REQ-007 The module SHALL have port mode, input, 1 bit: 0 = rotation (sin/cos), 1 = vectoring (magnitude/atan).
REQ-008 The module SHALL have port shift_region_flag, input, 2 bits, the rotation-mode quadrant: 00 none, 01 +pi/2, 10 -pi/2, 11 +pi.
REQ-009 The module SHALL have ports data_x, data_y and data_z, input, W bits each, as the operands.
REQ-010 The module SHALL have port ready_cordic, output, 1 bit, asserted when the result is valid.
REQ-011 The module SHALL have port busy, output, 1 bit, high in every state other than IDLE.
REQ-012 The module SHALL have ports result_x, result_y and result_z, output, W bits each.
REQ-013 The module SHALL have ports overflow_flag and range_err, output, 1 bit each.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, ITERATE, CORRECT and DONE, with no other states.
REQ-015 IDLE SHALL go to LOAD when beg_fsm_cordic=1, and all operands SHALL be registered on that edge.
REQ-016 LOAD SHALL last 1 cycle, ITERATE SHALL last exactly ITER cycles counted by a counter running 0..ITER-1, and CORRECT SHALL last 1 cycle.
REQ-017 ready_cordic SHALL rise exactly ITER+2 cycles after the edge that samples beg_fsm_cordic.
REQ-018 In DONE, ready_cordic and all results SHALL be held stable until ack_cordic=1, after which the FSM SHALL return to IDLE on the next edge.
REQ-019 beg_fsm_cordic SHALL be ignored outside IDLE; when beg and ack are both high in DONE, ack SHALL win and the start SHALL be dropped.
REQ-020 Rotation initial values SHALL be x0=K=0x26DD3B6A (W=32), y0=0, z0=data_z; data_x and data_y SHALL be ignored.
REQ-021 In rotation mode, result_x SHALL be cos and result_y SHALL be sin.
REQ-022 In vectoring mode, the initial values SHALL be x0=data_x, y0=data_y, z0=0, and shift_region_flag SHALL be ignored.
REQ-023 In vectoring mode, result_x SHALL be the magnitude times gain An (uncompensated) and result_z SHALL be atan(y/x).
REQ-024 Iteration i SHALL compute d=sign(z) in rotation mode or d=-sign(y) in vectoring mode, then x-=d*(y>>>i), y+=d*(x>>>i), z-=d*atan(2^-i).
REQ-025 Datapath registers SHALL carry 2 guard MSBs (W+2 bits).
REQ-026 CORRECT SHALL apply the region on (cos,sin): 01 gives (-sin,cos), 10 gives (sin,-cos), 11 gives (-cos,-sin).
REQ-027 CORRECT SHALL saturate each result to W bits (0x7FFF..., 0x8000...) and set overflow_flag if any saturation occurred.
REQ-028 range_err SHALL be set in rotation mode when |data_z| > pi/2 (0x6487ED51) and in vectoring mode when data_x < 0; the result SHALL still be produced.
REQ-029 Flags SHALL be valid with ready_cordic and SHALL be cleared on entry to LOAD.

Reset
REQ-030 rst=0 SHALL immediately force IDLE and the counter to 0, and clear ready_cordic, busy, all results and both flags, including in the middle of an operation.
REQ-031 After rst is released, the module SHALL accept beg_fsm_cordic on the first clock edge.

Structure
REQ-032 Package cordic_pkg SHALL hold the state enum, the atan table (32 entries, Q2.30, truncated to W), K, PI_2 and the Q-format constants.
REQ-033 One sub-module, cordic_micro_rotation, SHALL perform a single combinational shift-add step driven by the shift index, direction and atan entry.

Verification (W=32, ITER=24, tolerance ±256 LSB)
REQ-034 Rotation with z=0x3243F6A8 (pi/4) and region 00 SHALL give result_x≈result_y≈0x2D413CCD, flags 0, and ready exactly at cycle 26.
REQ-035 Rotation with z=0 and region 01 SHALL give result_x≈0 and result_y≈0x40000000.
REQ-036 Rotation with z=0x7FFFFFFF SHALL raise range_err=1, and ready SHALL still assert.
REQ-037 Vectoring with x=y=0x40000000 SHALL saturate result_x to 0x7FFFFFFF with overflow_flag=1 and result_z≈0x3243F6A8.
REQ-038 ready held with ack low for 10 cycles SHALL keep outputs stable; simultaneous ack+beg SHALL return to IDLE without restarting.
REQ-039 rst pulsed low at ITERATE cycle 5 SHALL clear all outputs at once, and a fresh start afterwards SHALL complete correctly.
